dm_responder: RTL

//  Data-memory slave answering the CPU datapath's load/store requests over a valid/ready

---
 rtl/dm_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// ---------------------------------------------------------------------------
// dm_responder
// Data-memory slave for the CPU datapath. Requests arrive on a valid/ready
// channel, wait a programmable number of cycles, touch a single-port word
// array (byte-lane writes, registered full-word reads), and are answered on a
// valid/ready response channel. Misaligned or out-of-range addresses are
// answered with an error and never reach the array. Only one request is in
// flight at a time.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  request present
//   req_ready  responder accepts a request this cycle (IDLE only)
//   req_we     1 = store, 0 = load
//   req_be     store byte enables, bit i covers bits [8i+7:8i]
//   req_addr   byte address
//   req_wdata  store data
//   rsp_valid  response present
//   rsp_ready  CPU consumes the response this cycle
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_err    request was misaligned or out of range
//   busy       FSM is not idle
// ---------------------------------------------------------------------------
module dm_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic              lat_err;
  logic [3:0]        lat_be;
  logic [ADDR_W-1:0] lat_word;
  logic [31:0]       lat_wdata;
  logic              accept;
  logic              addr_bad;

  logic [31:0] mem [DEPTH];

  // req_ready is held low while reset is asserted so nothing is offered as
  // acceptable until the block is actually running.
  assign req_ready = (state == S_IDLE) & reset;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid & req_ready;
  assign addr_bad  = (req_addr[1:0] != 2'b00) | (|req_addr[31:ADDR_W+2]);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Error requests skip the wait states but still spend
  // the single ACCESS cycle (with the array untouched), so their response
  // shows up one edge after acceptance, like a zero-wait valid request.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (addr_bad || (WAIT_CYCLES == 0)) begin
            next_state = S_ACCESS;
          end else begin
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        next_state = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Wait-state counter: loaded on acceptance, counts down to 1 in WAIT so
  // WAIT lasts exactly WAIT_CYCLES cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(WAIT_CYCLES);
    end else if (state == S_WAIT) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Request capture: fields are sampled once at acceptance and the request
  // inputs are ignored from then on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_be    <= 4'h0;
      lat_word  <= '0;
      lat_wdata <= 32'h0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_err   <= addr_bad;
      lat_be    <= req_be;
      lat_word  <= req_addr[ADDR_W+1:2];
      lat_wdata <= req_wdata;
    end
  end

  // Response registers: filled in the ACCESS cycle, held through RESP until
  // the CPU takes them, then cleared. Loads read the whole word regardless
  // of byte enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (state == S_ACCESS) begin
      rsp_err   <= lat_err;
      rsp_rdata <= (lat_we || lat_err) ? 32'h0 : mem[lat_word];
    end else if ((state == S_RESP) && rsp_ready) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end
  end

  // Single write port. The array has no reset; an async reset before the
  // ACCESS edge forces the FSM out of ACCESS and so suppresses the write.
  always_ff @(posedge clk) begin
    if ((state == S_ACCESS) && lat_we && !lat_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) begin
          mem[lat_word][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
